// File: rtl/sme_feeder.sv
// sme_feeder: buffers host string/pattern records and replays them to the SME core, returning pattern results
module sme_feeder #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_kind,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout,
  output logic       err_overflow
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, RESULT} state_t;
  state_t state, state_n;
  logic [7:0] mem [MAX_LEN];
  logic [CW-1:0] count, lim;
  logic [AW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic kind, ovf_seen, hs, send_done, wait_done, hit;
  assign hs = in_valid && in_ready;
  assign lim = ((state == IDLE) ? in_kind : kind) ? CW'(8) : CW'(MAX_LEN);
  assign send_done = CW'(idx) == count - CW'(1);
  assign wait_done = wcnt == WW'(TIMEOUT - 1);
  assign hit = sme_valid && sme_match;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = hs ? (in_last ? SEND : LOAD) : IDLE;
      LOAD:    state_n = (hs && in_last) ? SEND : LOAD;
      SEND:    state_n = send_done ? (kind ? WAIT : IDLE) : SEND;
      WAIT:    state_n = (sme_valid || wait_done) ? RESULT : WAIT;
      RESULT:  state_n = res_ready ? IDLE : RESULT;
      default: state_n = IDLE;
    endcase
  end
  // buffer storage carries no reset; count bounds what is replayed
  always_ff @(posedge clk) begin
    if (hs && state == IDLE) mem[0] <= in_char;
    if (hs && state == LOAD && count < lim) mem[count[AW-1:0]] <= in_char;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      idx           <= '0;
      wcnt          <= '0;
      kind          <= 1'b0;
      ovf_seen      <= 1'b0;
      in_ready      <= 1'b0;
      sme_chardata  <= '0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      res_valid     <= 1'b0;
      res_match     <= 1'b0;
      res_index     <= '0;
      res_timeout   <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      state         <= state_n;
      in_ready      <= state_n == IDLE || state_n == LOAD;
      err_overflow  <= 1'b0;
      sme_isstring  <= 1'b0;
      sme_ispattern <= 1'b0;
      wcnt          <= (state == WAIT) ? wcnt + 1'b1 : '0;
      if (hs && state == IDLE) begin
        kind     <= in_kind;
        count    <= CW'(1);
        ovf_seen <= 1'b0;
      end
      if (hs && state == LOAD) begin
        if (count < lim) count <= count + 1'b1;
        else begin
          ovf_seen     <= 1'b1;
          err_overflow <= !ovf_seen;
        end
      end
      if (state == SEND) begin
        sme_chardata  <= mem[idx];
        sme_isstring  <= !kind;
        sme_ispattern <= kind;
        idx           <= send_done ? '0 : idx + 1'b1;
      end
      if (state == WAIT && state_n == RESULT) begin
        res_valid   <= 1'b1;
        res_match   <= hit;
        res_index   <= hit ? sme_match_index : '0;
        res_timeout <= !sme_valid;
      end
      if (state == RESULT && res_ready) res_valid <= 1'b0;
    end
  end
endmodule
